// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator result path.
//   RESULT_W / BCD_DIGITS / CNT_W : default widths of the result decoder
//   state_t + IDLE/SHIFT/FINISH   : conversion FSM encoding
//   BCD_ADJ_THRESH / BCD_ADJ_ADD  : double-dabble digit correction constants
package calc_pkg;

    localparam int RESULT_W   = 20;
    localparam int BCD_DIGITS = 6;
    localparam int CNT_W      = 5;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t FINISH = 2'd2;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: combinational double-dabble correction for one BCD digit.
//   digit : 4-bit BCD digit before the shift
//   adj   : digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_digit_adjust
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    assign adj = (digit >= BCD_ADJ_THRESH) ? (digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/bcd_result_decoder.sv
// bcd_result_decoder: converts a two's-complement result into sign + packed BCD
// using iterative double-dabble (one shift per clock).
//   clk, rst : clock, synchronous active-high reset
//   start    : conversion request, honoured only when idle
//   value    : two's-complement operand, captured with start
//   busy     : conversion in progress
//   done     : one-cycle pulse; bcd/neg (and digit_en) are new in this cycle
//   neg      : sign of the last converted value
//   bcd      : packed BCD magnitude, digit 0 in bits [3:0]
//   digit_en : leading-zero blanking mask, present only with BCD_LEAD_BLANK_EN
module bcd_result_decoder #(
    parameter int IN_W   = calc_pkg::RESULT_W,
    parameter int DIGITS = calc_pkg::BCD_DIGITS,
    parameter int CNT_W  = calc_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_LEAD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     digit_en
`endif
);
    import calc_pkg::*;

    localparam int BCD_W = 4 * DIGITS;

    state_t            state;
    logic [BCD_W-1:0]  scratch;
    logic [BCD_W-1:0]  scratch_adj;
    logic [BCD_W-1:0]  scratch_nxt;
    logic [IN_W-1:0]   mag;
    logic              neg_n;
    logic [CNT_W-1:0]  cnt;
    logic              last_iter;
    logic              unused_top_bit;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit (scratch[4*g +: 4]),
            .adj   (scratch_adj[4*g +: 4])
        );
    end

    // The bit shifted out of the top digit is always 0 because 10^DIGITS
    // exceeds the largest magnitude.
    assign scratch_nxt    = {scratch_adj[BCD_W-2:0], mag[IN_W-1]};
    assign unused_top_bit = scratch_adj[BCD_W-1];
    assign last_iter      = (cnt == CNT_W'(IN_W - 1));

`ifdef BCD_LEAD_BLANK_EN
    logic [DIGITS-1:0] en_nxt;

    // A digit is shown when it or any more significant digit is nonzero;
    // the units digit is always shown so zero displays as "0".
    always_comb begin
        logic any_nz;
        any_nz = 1'b0;
        en_nxt = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any_nz    = any_nz | (|scratch_nxt[4*i +: 4]);
            en_nxt[i] = any_nz;
        end
        en_nxt[0] = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            mag     <= '0;
            neg_n   <= 1'b0;
            cnt     <= '0;
`ifdef BCD_LEAD_BLANK_EN
            digit_en <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_n   <= value[IN_W-1];
                        // Unsigned IN_W-bit magnitude: the most negative
                        // input maps to 2^(IN_W-1) without overflow.
                        mag     <= value[IN_W-1] ? (~value + 1'b1) : value;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    mag     <= {mag[IN_W-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                    if (last_iter) begin
                        // Results are loaded on entry to FINISH so they are
                        // already valid while done is high.
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= scratch_nxt;
                        neg   <= neg_n;
`ifdef BCD_LEAD_BLANK_EN
                        digit_en <= en_nxt;
`endif
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_result_decoder.sv
// tb_bcd_result_decoder: directed bench for bcd_result_decoder with a
// cycle-level reference model and hand-computed literal expectations.
// Define BCD_LEAD_BLANK_EN to also cover the digit_en output.
module tb_bcd_result_decoder;

    localparam int IN_W   = 20;
    localparam int DIGITS = 6;
    localparam int BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [IN_W-1:0]   value = '0;
    logic              busy;
    logic              done;
    logic              neg;
    logic [BW-1:0]     bcd;
`ifdef BCD_LEAD_BLANK_EN
    logic [DIGITS-1:0] digit_en;
`endif

    bcd_result_decoder #(
        .IN_W   (IN_W),
        .DIGITS (DIGITS),
        .CNT_W  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .neg      (neg),
        .bcd      (bcd)
`ifdef BCD_LEAD_BLANK_EN
        ,
        .digit_en (digit_en)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Decimal digits of |v| from plain integer arithmetic.
    function automatic logic [BW-1:0] exp_bcd(input logic [IN_W-1:0] v);
        int s;
        int m;
        logic [BW-1:0] r;
        s = $signed(v);
        m = (s < 0) ? -s : s;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] exp_en(input logic [BW-1:0] b);
        logic [DIGITS-1:0] e;
        bit seen;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (b[4*i +: 4] != 4'd0) seen = 1'b1;
            e[i] = seen;
        end
        e[0] = 1'b1;
        return e;
    endfunction

    // Reference model: a request seen while idle completes IN_W+1 cycles later.
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic              m_neg  = 1'b0;
    logic [BW-1:0]     m_bcd  = '0;
    logic [DIGITS-1:0] m_en   = '0;
    int                m_left = 0;
    logic              p_neg  = 1'b0;
    logic [BW-1:0]     p_bcd  = '0;
    logic [DIGITS-1:0] p_en   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_neg  <= 1'b0;
            m_bcd  <= '0;
            m_en   <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_neg  <= p_neg;
                m_bcd  <= p_bcd;
                m_en   <= p_en;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_busy <= 1'b1;
            m_left <= IN_W;
            p_neg  <= value[IN_W-1];
            p_bcd  <= exp_bcd(value);
            p_en   <= exp_en(exp_bcd(value));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
            check("model_neg",  32'(neg),  32'(m_neg));
            check("model_bcd",  32'(bcd),  32'(m_bcd));
`ifdef BCD_LEAD_BLANK_EN
            check("model_digit_en", 32'(digit_en), 32'(m_en));
`endif
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for done; n is the cycle index relative to the start cycle.
    task automatic wait_done(inout int n, output int busy_cycles);
        busy_cycles = 0;
        while (n < 40) begin
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy === 1'b1) busy_cycles++;
            n++;
            tick();
        end
    endtask

    task automatic run_conv(input logic [IN_W-1:0] v, input logic exp_neg,
                            input logic [BW-1:0] exp_b, input string nm);
        int n;
        int bc;
        start = 1'b1;
        value = v;
        tick();
        start = 1'b0;
        value = ~v;  // must not disturb the running conversion
        n = 1;
        wait_done(n, bc);
        check({nm, "_latency"}, 32'(n), 32'd21);
        check({nm, "_busy_cycles"}, 32'(bc), 32'd20);
        check({nm, "_neg"}, 32'(neg), 32'(exp_neg));
        check({nm, "_bcd"}, 32'(bcd), 32'(exp_b));
        tick();
    endtask

    initial begin
        int n;
        int bc;
        int d0;

        // Pin the model against hand-computed values.
        check("model_pin_min", 32'(exp_bcd(20'h80000)), 32'h524288);
        check("model_pin_m1",  32'(exp_bcd(20'hFFFFF)), 32'h000001);
        check("model_pin_en",  32'(exp_en(24'h000305)), 32'b000111);

        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_neg",  32'(neg),  32'd0);
        check("rst_bcd",  32'(bcd),  32'd0);
`ifdef BCD_LEAD_BLANK_EN
        check("rst_digit_en", 32'(digit_en), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();

        run_conv(20'd5,      1'b0, 24'h000005, "five");
        run_conv(20'hFFFFF,  1'b1, 24'h000001, "minus1");
        run_conv(20'd131071, 1'b0, 24'h131071, "pos131071");
        run_conv(20'hE0001,  1'b1, 24'h131071, "neg131071");
        run_conv(20'h80000,  1'b1, 24'h524288, "most_neg");
        run_conv(20'h7FFFF,  1'b0, 24'h524287, "most_pos");
        run_conv(20'd305,    1'b0, 24'h000305, "v305");
`ifdef BCD_LEAD_BLANK_EN
        check("v305_digit_en", 32'(digit_en), 32'b000111);
`endif
        run_conv(20'd0,      1'b0, 24'h000000, "zero");
`ifdef BCD_LEAD_BLANK_EN
        check("zero_digit_en", 32'(digit_en), 32'b000001);
`endif

        // Start while busy is ignored and not queued.
        start = 1'b1;
        value = 20'd42;
        tick();
        start = 1'b0;
        repeat (9) tick();
        start = 1'b1;
        value = 20'd99;
        tick();
        start = 1'b0;
        n = 11;
        wait_done(n, bc);
        check("ignore_latency", 32'(n), 32'd21);
        check("ignore_bcd", 32'(bcd), 32'h000042);
        tick();
        d0 = done_cnt;
        repeat (30) tick();
        check("ignore_no_second_done", 32'(done_cnt), 32'(d0));

        // Reset mid-conversion aborts it.
        start = 1'b1;
        value = 20'd777;
        tick();
        start = 1'b0;
        repeat (7) tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd",  32'(bcd),  32'd0);
        check("abort_neg",  32'(neg),  32'd0);
        tick();
        repeat (30) tick();
        check("abort_no_done", 32'(done_cnt), 32'(d0));

        // Start coincident with reset: reset wins.
        rst = 1'b1;
        start = 1'b1;
        value = 20'd5;
        tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        tick();

        run_conv(20'd777, 1'b0, 24'h000777, "after_abort");
        run_conv(20'hFFC18, 1'b1, 24'h001000, "minus1000");

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_result_decoder.md
Name: bcd_result_decoder

Overview:
- Consumer end of the calculator datapath. Takes the 20-bit two's-complement result produced by the add/subtract units.
- Decodes it into a sign flag and packed BCD digits for the 7-segment display driver.
- Conversion is iterative double-dabble, one shift per clock, with a start/busy/done handshake.
- Sits between the arithmetic units and the display multiplexer.

Parameters:
- IN_W, 20, width of the two's-complement input value.
- DIGITS, 6, number of BCD output digits. Constraint: 10^DIGITS > 2^(IN_W-1); the defaults satisfy it.
- CNT_W, 5, width of the iteration counter. Must hold IN_W.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to convert value; sampled only in IDLE.
- value  input  IN_W  two's-complement operand, sampled in the start cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when bcd and neg are updated.
- neg  output  1  sign of the last converted value (1 = negative).
- bcd  output  4*DIGITS  magnitude in packed BCD; digit 0 is in bits [3:0].

Behaviour:
- Reset values: busy=0, done=0, neg=0, bcd=0. FSM goes to IDLE; internal shift register and counter are cleared. A reset in any state aborts the conversion; no done pulse follows.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On start=1, latch neg_n = value[IN_W-1] and mag = neg_n ? (~value + 1) : value. mag is unsigned IN_W bits.
  - The most-negative input (0x80000 at default) therefore gives mag = 2^(IN_W-1) with no overflow.
  - Clear the BCD scratch register and counter, set busy=1, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every scratch digit >= 5 gets +3.
  - Then {scratch, mag} shifts left by 1.
  - The counter increments; after exactly IN_W iterations go to FINISH.
- FINISH:
  - Register bcd <= scratch and neg <= neg_n.
  - Assert done=1 for this one cycle, clear busy, return to IDLE.
- Latency: with start high in cycle 0, done is high in cycle IN_W+1 (cycle 21 at default).
- bcd and neg update only in the FINISH cycle. They hold their previous values throughout a conversion.
- start while busy=1 (SHIFT or FINISH) is ignored and not queued.
- start in the same cycle as rst: rst wins, no conversion.
- value changes after the start cycle have no effect.
- A zero result gives neg=0, bcd=0. A negative zero cannot occur.
- Back-to-back use: start may be asserted in the cycle after done; a new conversion begins from IDLE.

Optional Feature:
- Macro: BCD_LEAD_BLANK_EN.
- Defined:
  - Adds output digit_en [DIGITS-1:0], reset to 0 and updated in the FINISH cycle together with bcd.
  - digit_en[i]=1 if digit i is nonzero or any higher digit is nonzero. digit_en[0] is always 1 after the first conversion.
  - The display blanks leading zeros using this mask.
- Undefined:
  - The port and its logic are absent.
  - The display shows all DIGITS digits, including leading zeros.

Decomposition:
- Shared package calc_pkg holds:
  - RESULT_W=20, BCD_DIGITS=6, CNT_W=5;
  - the FSM state encoding typedef (IDLE, SHIFT, FINISH);
  - BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3.
- One natural sub-module: bcd_digit_adjust. It is combinational: a 4-bit digit in, the digit plus 3 out if the input is >= 5. It is instantiated DIGITS times in a generate loop.

Test Plan:
- value=20'd5, start pulse -> done at cycle 21, neg=0, bcd=24'h000005, busy high cycles 1-20.
- value=20'hFFFFF (-1) -> neg=1, bcd=24'h000001.
- value=20'd131071 -> neg=0, bcd=24'h131071. Then value=-131071 (20'hE0001) -> neg=1, bcd=24'h131071.
- value=20'h80000 (-524288) -> neg=1, bcd=24'h524288. value=20'h7FFFF -> neg=0, bcd=24'h524287.
- Convert 42, then pulse start with value=99 at cycle 10 -> second start ignored, bcd=24'h000042 at done, no second done pulse.
- Start value=777, assert rst at cycle 8 -> busy=0, bcd=0, neg=0, no done. A fresh start afterwards converts normally.
- With BCD_LEAD_BLANK_EN: value=20'd305 -> digit_en=6'b000111. value=0 -> digit_en=6'b000001.
